fact_sched: RTL

- Time-shares one iterative factorial engine among NUM_REQ requesters.
- Round-robin arbitration; per-requester valid/ready request port; single shared response channel tagged with requester id.
- Sits between client blocks needing n! and the multiply datapath; one calculation in flight at a time.

---
 rtl/fact_pkg.sv | 35 +++
 rtl/fact_sched_if.sv | 29 ++
 rtl/fact_engine.sv | 43 ++++
 rtl/fact_sched.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared types, default widths and the arbitration helper for fact_sched.
// FACT_FIXED_PRIO_EN (see fact_sched.sv) selects fixed priority instead of round-robin.
package fact_pkg;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned ID_W_DEF    = 2;
    localparam int unsigned IN_W_DEF    = 4;
    localparam int unsigned OUT_W_DEF   = 16;

    // Upper bound on requesters the grant search can handle.
    localparam int unsigned MAX_REQ = 32;

    // First asserted valid at or above ptr, wrapping at num. Returns 0 if none.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                            input int unsigned num,
                                            input int unsigned ptr);
        int unsigned idx;
        int unsigned pick;
        logic        found;
        pick  = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= num) idx = idx - num;
            if ((k < num) && !found && valid[idx[4:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fact_sched_if.sv
// Request/response bundle between the clients (master) and fact_sched (slave).
interface fact_sched_if import fact_pkg::*; #(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ID_W    = ID_W_DEF,
    parameter int unsigned IN_W    = IN_W_DEF,
    parameter int unsigned OUT_W   = OUT_W_DEF
) ();

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*IN_W-1:0] req_num;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [OUT_W-1:0]        resp_data;
    logic [ID_W-1:0]         resp_id;
    logic                    resp_ovf;
    logic                    busy;

    modport master (
        output req_valid, req_num, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, resp_ovf, busy
    );

    modport slave (
        input  req_valid, req_num, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, resp_ovf, busy
    );

endinterface

// File: rtl/fact_engine.sv
// Iterative factorial datapath: one multiply per cycle, counting n down to 1.
module fact_engine import fact_pkg::*; #(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  n,
    output logic             done,
    output logic [OUT_W-1:0] result,
    output logic             ovf
);

    logic [IN_W-1:0]       cnt_q;
    logic [OUT_W-1:0]      acc_q;
    logic                  ovf_q;
    logic [OUT_W+IN_W-1:0] prod;

    // Full-width product so the bits lost to truncation can flag overflow.
    assign prod   = {{IN_W{1'b0}}, acc_q} * {{OUT_W{1'b0}}, cnt_q};
    assign done   = (cnt_q <= IN_W'(1));
    assign result = acc_q;
    assign ovf    = ovf_q;

    // Load on start, otherwise multiply down until the counter reaches 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (start) begin
            cnt_q <= n;
            acc_q <= OUT_W'(1);
            ovf_q <= 1'b0;
        end else if (!done) begin
            cnt_q <= cnt_q - 1'b1;
            acc_q <= prod[OUT_W-1:0];
            ovf_q <= ovf_q | (|prod[OUT_W+IN_W-1:OUT_W]);
        end
    end

endmodule

// File: rtl/fact_sched.sv
// Shares one fact_engine among NUM_REQ requesters; one calculation in flight.
// Define FACT_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module fact_sched import fact_pkg::*; #(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ID_W    = ID_W_DEF,
    parameter int unsigned IN_W    = IN_W_DEF,
    parameter int unsigned OUT_W   = OUT_W_DEF
) (
    input logic         clk,
    input logic         rst,
    fact_sched_if.slave bus
);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_q;
    logic [IN_W-1:0]  grant_num;
    logic             any_valid;
    logic             start;
    logic             eng_done;
    logic             eng_ovf;
    logic [OUT_W-1:0] eng_result;
    logic [OUT_W-1:0] resp_data_q;
    logic [ID_W-1:0]  resp_id_q;
    logic             resp_ovf_q;

`ifdef FACT_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [ID_W-1:0] rr_ptr_q;

    // Next search starts just past the requester whose response was taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if ((state_q == RESP) && bus.resp_ready) begin
            rr_ptr_q <= (resp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : resp_id_q + 1'b1;
        end
    end

    assign rr_ptr = rr_ptr_q;
`endif

    assign any_valid = |bus.req_valid;
    assign grant     = ID_W'(rr_pick(MAX_REQ'(bus.req_valid), NUM_REQ, int'(rr_ptr)));

    // Operand of the granted requester.
    always_comb begin
        grant_num = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) grant_num = bus.req_num[i*IN_W +: IN_W];
        end
    end

    // Next state, combinational ready and engine start.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        start         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    bus.req_ready[grant] = 1'b1;
                    start                = 1'b1;
                    state_d              = CALC;
                end
            end
            CALC: begin
                if (eng_done) state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Served requester id, captured at accept.
    always_ff @(posedge clk) begin
        if (rst)        id_q <= '0;
        else if (start) id_q <= grant;
    end

    // Response registers, loaded once when the engine finishes and held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data_q <= '0;
            resp_id_q   <= '0;
            resp_ovf_q  <= 1'b0;
        end else if ((state_q == CALC) && eng_done) begin
            resp_data_q <= eng_result;
            resp_id_q   <= id_q;
            resp_ovf_q  <= eng_ovf;
        end
    end

    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_ovf   = resp_ovf_q;
    assign bus.busy       = (state_q != IDLE);

    fact_engine #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_engine (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .n      (grant_num),
        .done   (eng_done),
        .result (eng_result),
        .ovf    (eng_ovf)
    );

endmodule
